// File: rtl/la_capture.sv
`default_nettype none
// ============================================================================
// Module      : la_capture
// Description : Logic-analyzer capture engine. Samples a 16-bit probe bus
//               into a circular buffer once armed, fires on a masked pattern
//               match, stores a programmable number of post-trigger samples
//               and streams the captured window out oldest-first over a
//               valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module la_capture #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           probe,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [15:0]           trig_mask,
    input  logic [15:0]           trig_value,
    input  logic [DEPTH_LOG2-1:0] post_len,
    output logic [15:0]           rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last,
    output logic [DEPTH_LOG2-1:0] trig_pos,
    output logic                  armed,
    output logic                  triggered,
    output logic                  done
);

    localparam int c_DEPTH = 2 ** DEPTH_LOG2;
    // valid_cnt saturates at DEPTH, which needs one extra bit
    localparam logic [DEPTH_LOG2:0] c_VCNT_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_ARMED = 4'b0010,
        ST_TRIG  = 4'b0100,
        ST_DONE  = 4'b1000
    } state_t;

    state_t                r_state;
    logic [15:0]           r_probe_q;
    logic [15:0]           r_mask;
    logic [15:0]           r_value;
    logic [DEPTH_LOG2-1:0] r_post_len;
    logic [DEPTH_LOG2-1:0] r_post_cnt;
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2:0]   r_vcnt;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_rem;
    logic [15:0]           r_mem [c_DEPTH];
    logic [15:0]           r_mem_q;
    logic                  r_m_valid;
    logic                  r_m_last;
    logic [15:0]           r_rd_data;
    logic                  r_rd_valid;
    logic                  r_rd_last;
    logic [DEPTH_LOG2-1:0] r_trig_pos;
    logic                  r_armed;
    logic                  r_triggered;
    logic                  r_done;

    logic                  w_match;
    logic                  w_capturing;
    logic [DEPTH_LOG2-1:0] w_wr_ptr_nxt;
    logic [DEPTH_LOG2:0]   w_vcnt_nxt;
    logic                  w_out_ready;
    logic                  w_m_ready;
    logic                  w_fetch;
    logic                  w_rd_accept_last;

    assign w_match          = ((r_probe_q & r_mask) == (r_value & r_mask));
    assign w_capturing      = (r_state == ST_ARMED) || (r_state == ST_TRIG);
    assign w_wr_ptr_nxt     = r_wr_ptr + 1'b1;
    assign w_vcnt_nxt       = (r_vcnt == c_VCNT_MAX) ? r_vcnt : r_vcnt + 1'b1;
    // Two-stage read pipeline: RAM output register feeding the port register.
    // A stage may load when it is empty or its content moves on this cycle.
    assign w_out_ready      = !r_rd_valid || rd_ready;
    assign w_m_ready        = !r_m_valid || w_out_ready;
    assign w_fetch          = (r_state == ST_DONE) && (r_rem != '0) && w_m_ready;
    assign w_rd_accept_last = r_rd_valid && rd_ready && r_rd_last;

    // Probe input register; every stored sample comes from here
    always_ff @(posedge clk) begin
        if (rst) begin
            r_probe_q <= '0;
        end else begin
            r_probe_q <= probe;
        end
    end

    // Capture RAM: one write per capturing cycle, synchronous read with enable
    // so a stalled fetch keeps its data
    always_ff @(posedge clk) begin
        if (w_capturing && !abort) begin
            r_mem[r_wr_ptr] <= r_probe_q;
        end
        if (w_fetch) begin
            r_mem_q <= r_mem[r_rd_ptr];
        end
    end

    // Capture state machine with flags registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mask      <= '0;
            r_value     <= '0;
            r_post_len  <= '0;
            r_post_cnt  <= '0;
            r_wr_ptr    <= '0;
            r_vcnt      <= '0;
            r_rd_ptr    <= '0;
            r_rem       <= '0;
            r_trig_pos  <= '0;
            r_armed     <= 1'b0;
            r_triggered <= 1'b0;
            r_done      <= 1'b0;
        end else if (abort) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_vcnt      <= '0;
            r_rem       <= '0;
            r_armed     <= 1'b0;
            r_triggered <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_wr_ptr <= '0;
                    r_vcnt   <= '0;
                    if (arm) begin
                        r_mask      <= trig_mask;
                        r_value     <= trig_value;
                        r_post_len  <= post_len;
                        r_state     <= ST_ARMED;
                        r_armed     <= 1'b1;
                        r_triggered <= 1'b0;
                        r_done      <= 1'b0;
                    end
                end
                ST_ARMED, ST_TRIG: begin
                    r_wr_ptr <= w_wr_ptr_nxt;
                    r_vcnt   <= w_vcnt_nxt;
                    if (r_state == ST_ARMED) begin
                        if (w_match) begin
                            r_post_cnt <= r_post_len;
                            if (r_post_len != '0) begin
                                r_state     <= ST_TRIG;
                                r_armed     <= 1'b1;
                                r_triggered <= 1'b1;
                                r_done      <= 1'b0;
                            end
                        end
                    end else begin
                        r_post_cnt <= r_post_cnt - 1'b1;
                    end
                    // Final write of the capture: set up the readout window
                    // from the pointer/count values this write produces
                    if ((r_state == ST_ARMED && w_match && r_post_len == '0) ||
                        (r_state == ST_TRIG && r_post_cnt == DEPTH_LOG2'(1))) begin
                        r_state     <= ST_DONE;
                        r_armed     <= 1'b0;
                        r_triggered <= 1'b1;
                        r_done      <= 1'b1;
                        r_rd_ptr    <= w_wr_ptr_nxt - w_vcnt_nxt[DEPTH_LOG2-1:0];
                        r_rem       <= w_vcnt_nxt;
                        r_trig_pos  <= w_vcnt_nxt[DEPTH_LOG2-1:0] - r_post_len - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (w_fetch) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                        r_rem    <= r_rem - 1'b1;
                    end
                    if (w_rd_accept_last) begin
                        r_state     <= ST_IDLE;
                        r_armed     <= 1'b0;
                        r_triggered <= 1'b0;
                        r_done      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_armed     <= 1'b0;
                    r_triggered <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    // Readout pipeline: RAM data stage then held output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid  <= 1'b0;
            r_m_last   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_rd_data  <= '0;
        end else if (abort) begin
            r_m_valid  <= 1'b0;
            r_m_last   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
        end else begin
            if (w_fetch) begin
                r_m_valid <= 1'b1;
                r_m_last  <= (r_rem == (DEPTH_LOG2 + 1)'(1));
            end else if (w_out_ready) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
            end
            if (w_out_ready) begin
                r_rd_valid <= r_m_valid;
                r_rd_last  <= r_m_valid && r_m_last;
                if (r_m_valid) begin
                    r_rd_data <= r_mem_q;
                end
            end
        end
    end

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign rd_last   = r_rd_last;
    assign trig_pos  = r_trig_pos;
    assign armed     = r_armed;
    assign triggered = r_triggered;
    assign done      = r_done;

endmodule
`default_nettype wire
